// File: rtl/uart_serial_receiver_if.sv
// Receive-FIFO pop port: head-of-queue character with its error flags and a
// valid/ready handshake. The receiver drives it as master; the consumer is the slave.
interface uart_serial_receiver_if;
   logic [7:0] data;
   logic       parity_err;
   logic       framing_err;
   logic       break_det;
   logic       valid;
   logic       ready;

   modport master (
      output data, parity_err, framing_err, break_det, valid,
      input  ready
   );

   modport slave (
      input  data, parity_err, framing_err, break_det, valid,
      output ready
   );
endinterface

// File: rtl/uart_serial_receiver.sv
// UART serial-line receiver: 16x oversampled deserializer with parity, framing
// and break detection, feeding a small receive FIFO with CTS-style flow control.
module uart_serial_receiver #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [15:0]                   divisor,
   input  logic [1:0]                    word_len,
   input  logic                          parity_en,
   input  logic                          parity_even,
   input  logic                          rx,
   uart_serial_receiver_if.master        fifo_if,
   output logic                          overrun,
   output logic                          cts_n
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
   } state_t;

   state_t            state, state_n;
   logic              rx_p0, rx_p1;
   logic              rxs;
   logic [15:0]       cfg_div;
   logic [1:0]        cfg_len;
   logic              cfg_pen;
   logic              cfg_peven;
   logic [15:0]       dmax;
   logic [15:0]       pre;
   logic              tick;
   logic [3:0]        tcnt;
   logic [2:0]        bcnt;
   logic [2:0]        last_bit;
   logic [7:0]        shreg;
   logic              par_bit;
   logic              mid_start;
   logic              bit_smp;
   logic              do_push;
   logic              exp_par;
   logic [10:0]       entry;
   logic [10:0]       mem [FIFO_DEPTH];
   logic [10:0]       head;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full, pop, wr_en, drop;

   // ---- stage p0/p1: two-flop synchronizer, reset to idle-high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
      end
   end
   assign rxs = rx_p1;

   // ---- configuration latch and 16x prescaler, both restarted at start detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_div   <= 16'd1;
         cfg_len   <= 2'd3;
         cfg_pen   <= 1'b0;
         cfg_peven <= 1'b0;
      end else if (state == IDLE && !rxs) begin
         cfg_div   <= divisor;
         cfg_len   <= word_len;
         cfg_pen   <= parity_en;
         cfg_peven <= parity_even;
      end
   end

   assign dmax = (cfg_div == 16'd0) ? 16'd1 : cfg_div;
   assign tick = (pre == dmax - 16'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        pre <= 16'd0;
      else if (state == IDLE || tick) pre <= 16'd0;
      else                            pre <= pre + 16'd1;
   end

   assign mid_start = (state == START) && tick && (tcnt == 4'd7);
   assign bit_smp   = tick && (tcnt == 4'd15);
   assign last_bit  = {1'b0, cfg_len} + 3'd4;

   // Tick counter realigns at mid-start so every later sample lands mid-bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             tcnt <= 4'd0;
      else if (state == IDLE || mid_start) tcnt <= 4'd0;
      else if (tick)                       tcnt <= tcnt + 4'd1;
   end

   // ---- frame state machine
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      do_push = 1'b0;
      case (state)
         IDLE:      if (!rxs) state_n = START;
         START:     if (mid_start) state_n = rxs ? IDLE : DATA;
         DATA:      if (bit_smp && bcnt == last_bit) state_n = cfg_pen ? PARITY : STOP;
         PARITY:    if (bit_smp) state_n = STOP;
         STOP: begin
            if (bit_smp) begin
               do_push = 1'b1;
               state_n = rxs ? IDLE : WAIT_IDLE;
            end
         end
         WAIT_IDLE: if (rxs) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   // ---- bit capture; cleared in IDLE so no reset is needed
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         shreg   <= 8'd0;
         bcnt    <= 3'd0;
         par_bit <= 1'b0;
      end else if (state == DATA && bit_smp) begin
         shreg[bcnt] <= rxs;
         bcnt        <= bcnt + 3'd1;
      end else if (state == PARITY && bit_smp) begin
         par_bit <= rxs;
      end
   end

   assign exp_par = (^shreg) ^ ~cfg_peven;
   assign entry   = { (shreg == 8'd0) && !par_bit && !rxs,
                      !rxs,
                      cfg_pen && (par_bit != exp_par),
                      shreg };

   // ---- receive FIFO
   assign full  = (count == CNT_W'(FIFO_DEPTH));
   assign pop   = fifo_if.valid && fifo_if.ready;
   assign wr_en = do_push && (!full || pop);
   assign drop  = do_push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
         cts_n   <= 1'b0;
      end else begin
         overrun <= drop;
         cts_n   <= (count > CNT_W'(FIFO_DEPTH - 2));
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head fields read as zero while empty, so storage needs no reset.
   assign head                = mem[rd_ptr];
   assign fifo_if.valid       = (count != '0);
   assign fifo_if.data        = fifo_if.valid ? head[7:0] : 8'd0;
   assign fifo_if.parity_err  = fifo_if.valid & head[8];
   assign fifo_if.framing_err = fifo_if.valid & head[9];
   assign fifo_if.break_det   = fifo_if.valid & head[10];

endmodule

// File: tb/tb_uart_serial_receiver.sv
// Scoreboard bench for uart_serial_receiver: directed frames push expected
// entries; a monitor compares each popped FIFO entry against the queue.
module tb_uart_serial_receiver;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] divisor;
   logic [1:0]  word_len;
   logic        parity_en;
   logic        parity_even;
   logic        rx;
   logic        ready;
   logic        overrun;
   logic        cts_n;

   int total = 0;
   int bad   = 0;
   int pop_cnt = 0;
   int ovr_cnt = 0;
   logic [10:0] exp_q[$];

   always #5 clk = ~clk;

   uart_serial_receiver_if ifc();
   assign ifc.ready = ready;

   uart_serial_receiver #(.FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .divisor     (divisor),
      .word_len    (word_len),
      .parity_en   (parity_en),
      .parity_even (parity_even),
      .rx          (rx),
      .fifo_if     (ifc),
      .overrun     (overrun),
      .cts_n       (cts_n)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_entry(input logic [7:0] d, input bit pe, input bit fe, input bit brk);
      exp_q.push_back({brk, fe, pe, d});
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                             input bit pbit, input bit stopb, input int dv);
      int bt;
      bt = 16 * dv;
      rx = 1'b0;
      hold(bt);
      for (int i = 0; i < nbits; i++) begin
         rx = d[i];
         hold(bt);
      end
      if (pen) begin
         rx = pbit;
         hold(bt);
      end
      rx = stopb;
      hold(bt);
      rx = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ifc.valid) && n < 3000) begin
         hold(1);
         n++;
      end
      total++;
      if (n >= 3000) begin
         bad++;
         $display("FAIL %s: drain timeout, pending=%0d valid=%0b", name, exp_q.size(), ifc.valid);
      end
   endtask

   // Monitor: compare each popped entry against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (overrun) ovr_cnt++;
         if (ifc.valid && ifc.ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_entry: got 0x%0h expected none",
                        {ifc.break_det, ifc.framing_err, ifc.parity_err, ifc.data});
            end else begin
               check("entry", {ifc.break_det, ifc.framing_err, ifc.parity_err, ifc.data},
                     exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int p0;
      rst = 1'b1;
      rx = 1'b1;
      ready = 1'b0;
      divisor = 16'd1;
      word_len = 2'd3;
      parity_en = 1'b0;
      parity_even = 1'b0;
      #23;
      check("rst_valid", ifc.valid, 0);
      check("rst_data", ifc.data, 0);
      check("rst_flags", {ifc.break_det, ifc.framing_err, ifc.parity_err}, 0);
      check("rst_overrun", overrun, 0);
      check("rst_cts_n", cts_n, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      hold(20);

      // Single 8N1 frame with exact latency and pop
      expect_entry(8'h55, 0, 0, 0);
      fork
         send_frame(8'h55, 8, 0, 0, 1, 1);
         begin
            for (int n = 1; n <= 156; n++) begin
               hold(1);
               if (n == 154) check("lat_pre", ifc.valid, 0);
               if (n == 155) begin
                  check("lat_valid", ifc.valid, 1);
                  ready = 1'b1;
               end
               if (n == 156) check("pop_clear", ifc.valid, 0);
            end
         end
      join
      hold(20);

      // 7E1 parity error then correct parity; 8O1; 5N1 truncation
      word_len = 2'd2; parity_en = 1'b1; parity_even = 1'b1;
      expect_entry(8'h41, 1, 0, 0);
      send_frame(8'h41, 7, 1, 1, 1, 1);
      hold(4);
      expect_entry(8'h41, 0, 0, 0);
      send_frame(8'h41, 7, 1, 0, 1, 1);
      hold(4);
      word_len = 2'd3; parity_even = 1'b0;
      expect_entry(8'h80, 0, 0, 0);
      send_frame(8'h80, 8, 1, 0, 1, 1);
      hold(4);
      word_len = 2'd0; parity_en = 1'b0;
      expect_entry(8'h13, 0, 0, 0);
      send_frame(8'hF3, 5, 0, 0, 1, 1);
      hold(4);
      word_len = 2'd3;
      wait_drain("parity_drain");

      // Held break gives one entry; framing error with data
      p0 = pop_cnt;
      expect_entry(8'h00, 0, 1, 1);
      rx = 1'b0;
      hold(30 * 16);
      rx = 1'b1;
      hold(100);
      check("break_count", pop_cnt - p0, 1);
      expect_entry(8'h3C, 0, 0, 0);
      send_frame(8'h3C, 8, 0, 0, 1, 1);
      hold(4);
      expect_entry(8'h5A, 0, 1, 0);
      send_frame(8'h5A, 8, 0, 0, 0, 1);
      hold(20);
      wait_drain("break_drain");

      // Short glitch is a false start
      p0 = pop_cnt;
      rx = 1'b0;
      hold(5);
      rx = 1'b1;
      hold(300);
      check("glitch_valid", ifc.valid, 0);
      check("glitch_count", pop_cnt - p0, 0);

      // Overrun and flow control
      ready = 1'b0;
      ovr_cnt = 0;
      for (int f = 1; f <= 5; f++) begin
         if (f <= 4) expect_entry(8'(f), 0, 0, 0);
         send_frame(8'(f), 8, 0, 0, 1, 1);
         hold(2);
         if (f == 2) check("cts_after2", cts_n, 0);
         if (f == 3) check("cts_after3", cts_n, 1);
         if (f == 4) check("ovr_after4", ovr_cnt, 0);
         if (f == 5) check("ovr_after5", ovr_cnt, 1);
      end
      ready = 1'b1;
      wait_drain("overrun_drain");
      hold(3);
      check("cts_drained", cts_n, 0);

      // Reset mid-DATA discards FIFO and partial frame
      ready = 1'b0;
      send_frame(8'h99, 8, 0, 0, 1, 1);
      hold(4);
      check("pre_rst_valid", ifc.valid, 1);
      rx = 1'b0;
      hold(16);
      rx = 1'b1; hold(16);
      rx = 1'b1; hold(16);
      rx = 1'b1; hold(8);
      rst = 1'b1;
      #1;
      check("midrst_valid", ifc.valid, 0);
      check("midrst_data", ifc.data, 0);
      check("midrst_cts", cts_n, 0);
      hold(2);
      rst = 1'b0;
      hold(50);
      ready = 1'b1;
      expect_entry(8'hA3, 0, 0, 0);
      send_frame(8'hA3, 8, 0, 0, 1, 1);
      hold(4);
      wait_drain("rst_drain");

      // Divisor change mid-frame, divisor 0, divisor 3
      expect_entry(8'hC6, 0, 0, 0);
      fork
         send_frame(8'hC6, 8, 0, 0, 1, 1);
         begin
            hold(40);
            divisor = 16'd4;
         end
      join
      hold(4);
      wait_drain("divchg_drain");
      divisor = 16'd0;
      expect_entry(8'h3A, 0, 0, 0);
      send_frame(8'h3A, 8, 0, 0, 1, 1);
      hold(4);
      divisor = 16'd3;
      expect_entry(8'h96, 0, 0, 0);
      send_frame(8'h96, 8, 0, 0, 1, 3);
      hold(10);
      wait_drain("div_drain");

      hold(20);
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
